// File: rtl/random_ready_picker.sv
// Two-stage picker: fill mode issues sequential slot indices, shuffle mode picks a random ready slot.
// Optional macro PICK_EXCLUDE_EN suppresses repeat picks of a slot until its ready bit drops.
module random_ready_picker #(
  parameter int unsigned BS     = 16,
  parameter int unsigned RAND_W = 32,
  localparam int unsigned IDX_W = $clog2(BS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BS-1:0]     cand_list,
  input  logic [RAND_W-1:0] rand_num,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  buffer_index,
  output logic [IDX_W:0]    ready_count
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [BS-1:0]    s1_cand_q, s1_cand_d;
  logic [CNT_W-1:0] s1_rand_q, s1_rand_d;
  logic             s1_start_q, s1_start_d;
  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] buffer_index_q, buffer_index_d;
  logic [CNT_W-1:0] ready_count_q, ready_count_d;
  logic [IDX_W-1:0] fill_ptr_q, fill_ptr_d;

  logic             adv_c;
  logic             hs_shuf_c;
  logic [BS-1:0]    excl_c;
  logic [BS-1:0]    eff_c;
  logic [CNT_W-1:0] cnt_c;
  logic [CNT_W-1:0] sel_c;
  logic [CNT_W-1:0] seen_c;
  logic [IDX_W-1:0] pick_c;
  logic             unused_rand_c;

`ifdef PICK_EXCLUDE_EN
  logic [BS-1:0] mask_q, mask_d;
  logic [BS-1:0] bypass_c;
`endif

  // Only the low CNT_W random bits feed the modulo; the rest are intentionally dropped.
  assign unused_rand_c = ^rand_num;

  always_comb begin
    adv_c     = !out_valid_q || out_ready;
    // A nonzero ready_count marks the current output as a shuffle-mode pick.
    hs_shuf_c = out_valid_q && out_ready && (ready_count_q != '0);
    excl_c    = '0;
`ifdef PICK_EXCLUDE_EN
    bypass_c  = hs_shuf_c ? (BS'(1) << buffer_index_q) : '0;
    excl_c    = mask_q | bypass_c;
    mask_d    = (mask_q | bypass_c) & cand_list;
`endif
    eff_c = s1_cand_q & ~excl_c;

    cnt_c = '0;
    for (int k = 0; k < BS; k++) begin
      cnt_c = cnt_c + CNT_W'(eff_c[k]);
    end
    sel_c = (cnt_c == '0) ? '0 : (s1_rand_q % cnt_c);

    // Walk set bits in ascending order; the sel_c-th one is the pick.
    seen_c = '0;
    pick_c = '0;
    for (int k = 0; k < BS; k++) begin
      if (eff_c[k]) begin
        if (seen_c == sel_c) pick_c = IDX_W'(k);
        seen_c = seen_c + CNT_W'(1);
      end
    end
  end

  always_comb begin
    s1_cand_d      = s1_cand_q;
    s1_rand_d      = s1_rand_q;
    s1_start_d     = s1_start_q;
    s1_valid_d     = s1_valid_q;
    out_valid_d    = out_valid_q;
    buffer_index_d = buffer_index_q;
    ready_count_d  = ready_count_q;
    fill_ptr_d     = fill_ptr_q;
    if (adv_c) begin
      s1_cand_d  = cand_list;
      s1_rand_d  = rand_num[IDX_W:0];
      s1_start_d = start;
      s1_valid_d = 1'b1;
      if (s1_valid_q) begin
        if (!s1_start_q) begin
          buffer_index_d = fill_ptr_q;
          out_valid_d    = 1'b1;
          fill_ptr_d     = fill_ptr_q + IDX_W'(1);
          ready_count_d  = '0;
        end else begin
          ready_count_d = cnt_c;
          if (cnt_c != '0) begin
            buffer_index_d = pick_c;
            out_valid_d    = 1'b1;
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_cand_q      <= '0;
      s1_rand_q      <= '0;
      s1_start_q     <= 1'b0;
      s1_valid_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      buffer_index_q <= '1;
      ready_count_q  <= '0;
      fill_ptr_q     <= '0;
`ifdef PICK_EXCLUDE_EN
      mask_q         <= '0;
`endif
    end else begin
      s1_cand_q      <= s1_cand_d;
      s1_rand_q      <= s1_rand_d;
      s1_start_q     <= s1_start_d;
      s1_valid_q     <= s1_valid_d;
      out_valid_q    <= out_valid_d;
      buffer_index_q <= buffer_index_d;
      ready_count_q  <= ready_count_d;
      fill_ptr_q     <= fill_ptr_d;
`ifdef PICK_EXCLUDE_EN
      mask_q         <= mask_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign buffer_index = buffer_index_q;
  assign ready_count  = ready_count_q;

endmodule
